// File: rtl/stack_bank.sv
// stack_bank: NUM_STACKS independent LIFO channels.
// Each channel has its own storage, occupancy counter, stack pointer and registered top-of-stack.
// A channel's pointer grows up or down, selected by its GROW_DOWN bit.
// Optional feature macro: STACK_BANK_GUARD_EN.
//   When defined, a push onto a full channel and a pop from an empty channel are suppressed.
//   Those attempts set the sticky Overflow or Underflow flag.
//   When undefined, Count wraps modulo DEPTH+1 and both flags stay 0.
module stack_bank #(
  parameter int                          WIDTH      = 16,
  parameter int                          DEPTH      = 32,
  parameter int                          NUM_STACKS = 2,
  parameter logic [NUM_STACKS-1:0]       GROW_DOWN  = 2'b10,
  parameter logic [NUM_STACKS*WIDTH-1:0] STACK_BASE = {16'hFFFF, 16'h0000}
) (
  input  logic                                      CLK,
  input  logic                                      RST_N,
  input  logic [NUM_STACKS-1:0]                     Push,
  input  logic [NUM_STACKS-1:0]                     Pop,
  input  logic [NUM_STACKS-1:0]                     Flush,
  input  logic [NUM_STACKS*WIDTH-1:0]               PushData,
  output logic [NUM_STACKS*WIDTH-1:0]               TopOut,
  output logic [NUM_STACKS*WIDTH-1:0]               SPOut,
  output logic [NUM_STACKS*($clog2(DEPTH)+1)-1:0]   Count,
  output logic [NUM_STACKS-1:0]                     Full,
  output logic [NUM_STACKS-1:0]                     Empty,
  output logic [NUM_STACKS-1:0]                     Overflow,
  output logic [NUM_STACKS-1:0]                     Underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef STACK_BANK_GUARD_EN
  localparam bit GUARD_C = 1'b1;
`else
  localparam bit GUARD_C = 1'b0;
`endif

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE_C = CW'(32'd1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(32'd1);
  localparam logic [AW-1:0] PTR_TWO_C = AW'(32'd2);

  for (genvar i = 0; i < NUM_STACKS; i++) begin : gChan
    localparam logic [WIDTH-1:0] BASE_C = STACK_BASE[i*WIDTH +: WIDTH];
    localparam bit               DOWN_C = GROW_DOWN[i];

    // Storage plus a circular head index.
    // head_r is the slot the next push writes, so the top lives at head_r-1.
    // The index is kept separate from Count so that unguarded wrap overwrites the oldest slot.
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    head_r, headNext_s, memAddr_s;
    logic [CW-1:0]    count_r, countNext_s;
    logic [WIDTH-1:0] top_r, topNext_s, sp_r, spNext_s, pushData_s;
    logic             ovf_r, ovfNext_s, unf_r, unfNext_s, memWe_s;
    logic             isFull_s, isEmpty_s;
    logic             doFlush_s, doPush_s, doPop_s, doSwap_s, ovfSet_s, unfSet_s;

    assign pushData_s = PushData[i*WIDTH +: WIDTH];
    assign isFull_s   = (count_r == DEPTH_C);
    assign isEmpty_s  = (count_r == {CW{1'b0}});

    // Decode strobes into one operation; flush wins, an exchange on an empty stack becomes a push
    always_comb begin
      doFlush_s = 1'b0;
      doPush_s  = 1'b0;
      doPop_s   = 1'b0;
      doSwap_s  = 1'b0;
      ovfSet_s  = 1'b0;
      unfSet_s  = 1'b0;
      case ({Flush[i], Push[i], Pop[i]})
        3'b000: doFlush_s = 1'b0;
        3'b011: begin
          if (isEmpty_s) begin
            doPush_s = 1'b1;
          end else begin
            doSwap_s = 1'b1;
          end
        end
        3'b010: begin
          if (GUARD_C && isFull_s) begin
            ovfSet_s = 1'b1;
          end else begin
            doPush_s = 1'b1;
          end
        end
        3'b001: begin
          if (GUARD_C && isEmpty_s) begin
            unfSet_s = 1'b1;
          end else begin
            doPop_s = 1'b1;
          end
        end
        default: doFlush_s = 1'b1;
      endcase
    end

    // Next-state for count, head, top-of-stack, pointer and error flags
    always_comb begin
      countNext_s = count_r;
      headNext_s  = head_r;
      topNext_s   = top_r;
      ovfNext_s   = ovf_r | ovfSet_s;
      unfNext_s   = unf_r | unfSet_s;
      memWe_s     = 1'b0;
      memAddr_s   = head_r;
      if (doFlush_s) begin
        countNext_s = {CW{1'b0}};
        headNext_s  = {AW{1'b0}};
        topNext_s   = {WIDTH{1'b0}};
        ovfNext_s   = 1'b0;
        unfNext_s   = 1'b0;
      end else if (doPush_s) begin
        memWe_s     = 1'b1;
        headNext_s  = head_r + PTR_ONE_C;
        countNext_s = isFull_s ? {CW{1'b0}} : count_r + CNT_ONE_C;
        topNext_s   = isFull_s ? {WIDTH{1'b0}} : pushData_s;
      end else if (doSwap_s) begin
        memWe_s   = 1'b1;
        memAddr_s = head_r - PTR_ONE_C;
        topNext_s = pushData_s;
      end else if (doPop_s) begin
        headNext_s  = head_r - PTR_ONE_C;
        countNext_s = isEmpty_s ? DEPTH_C : count_r - CNT_ONE_C;
        topNext_s   = (count_r == CNT_ONE_C) ? {WIDTH{1'b0}} : mem_r[head_r - PTR_TWO_C];
      end else begin
        memWe_s = 1'b0;
      end
      spNext_s = DOWN_C ? (BASE_C - WIDTH'(countNext_s)) : (BASE_C + WIDTH'(countNext_s));
    end

    // Channel state registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        count_r <= {CW{1'b0}};
        head_r  <= {AW{1'b0}};
        top_r   <= {WIDTH{1'b0}};
        sp_r    <= BASE_C;
        ovf_r   <= 1'b0;
        unf_r   <= 1'b0;
      end else begin
        count_r <= countNext_s;
        head_r  <= headNext_s;
        top_r   <= topNext_s;
        sp_r    <= spNext_s;
        ovf_r   <= ovfNext_s;
        unf_r   <= unfNext_s;
      end
    end

    // Stack storage write port; contents are intentionally not reset
    always_ff @(posedge CLK) begin
      if (memWe_s) begin
        mem_r[memAddr_s] <= pushData_s;
      end
    end

    assign TopOut[i*WIDTH +: WIDTH] = top_r;
    assign SPOut[i*WIDTH +: WIDTH]  = sp_r;
    assign Count[i*CW +: CW]        = count_r;
    assign Full[i]                  = isFull_s;
    assign Empty[i]                 = isEmpty_s;
    assign Overflow[i]              = ovf_r;
    assign Underflow[i]             = unf_r;
  end

endmodule

// File: tb/tb_stack_bank.sv
// tb_stack_bank: scoreboard bench for stack_bank with default parameters.
// A plain array-based LIFO model produces the expected outputs for each driven cycle.
// Those expected outputs are queued and compared after the following rising edge.
module tb_stack_bank;

  localparam int D = 32;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  Push = 2'b00, Pop = 2'b00, Flush = 2'b00;
  logic [31:0] PushData = 32'h0;
  logic [31:0] TopOut, SPOut;
  logic [11:0] Count;
  logic [1:0]  Full, Empty, Overflow, Underflow;

  stack_bank dut (
    .CLK(CLK), .RST_N(RST_N), .Push(Push), .Pop(Pop), .Flush(Flush),
    .PushData(PushData), .TopOut(TopOut), .SPOut(SPOut), .Count(Count),
    .Full(Full), .Empty(Empty), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] top;
    logic [31:0] sp;
    logic [11:0] cnt;
    logic [1:0]  full;
    logic [1:0]  empty;
    logic [1:0]  ovf;
    logic [1:0]  unf;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] mdlMem [2][D];
  int          mdlCnt [2];
  bit          mdlOvf [2];
  bit          mdlUnf [2];
  int          checkCount = 0;
  int          errorCount = 0;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] want);
    checkCount++;
    if (got !== want) begin
      errorCount++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      int c;
      c = mdlCnt[i];
      e.top[i*16 +: 16] = (c == 0) ? 16'h0 : mdlMem[i][c-1];
      e.sp[i*16 +: 16]  = (i == 0) ? 16'(c) : 16'(16'hFFFF - 16'(c));
      e.cnt[i*6 +: 6]   = 6'(c);
      e.full[i]         = (c == D);
      e.empty[i]        = (c == 0);
      e.ovf[i]          = mdlOvf[i];
      e.unf[i]          = mdlUnf[i];
    end
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mdlCnt[i] = 0;
      mdlOvf[i] = 1'b0;
      mdlUnf[i] = 1'b0;
    end
  endtask

  task automatic modelOp(input int i, input bit pu, input bit po, input bit fl, input logic [15:0] d);
    if (fl) begin
      mdlCnt[i] = 0;
      mdlOvf[i] = 1'b0;
      mdlUnf[i] = 1'b0;
    end else if (pu && po) begin
      if (mdlCnt[i] == 0) begin
        mdlMem[i][0] = d;
        mdlCnt[i] = 1;
      end else begin
        mdlMem[i][mdlCnt[i]-1] = d;
      end
    end else if (pu) begin
      if (mdlCnt[i] == D) begin
`ifdef STACK_BANK_GUARD_EN
        mdlOvf[i] = 1'b1;
`else
        mdlCnt[i] = 0;
`endif
      end else begin
        mdlMem[i][mdlCnt[i]] = d;
        mdlCnt[i]++;
      end
    end else if (po) begin
      if (mdlCnt[i] == 0) begin
        mdlUnf[i] = 1'b1;
      end else begin
        mdlCnt[i]--;
      end
    end
  endtask

  task automatic compareNext(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checkValue({tag, ".queue"}, 64'd0, 64'd1);
    end else begin
      e = expQ.pop_front();
      checkValue({tag, ".top"},   64'(TopOut),    64'(e.top));
      checkValue({tag, ".sp"},    64'(SPOut),     64'(e.sp));
      checkValue({tag, ".cnt"},   64'(Count),     64'(e.cnt));
      checkValue({tag, ".full"},  64'(Full),      64'(e.full));
      checkValue({tag, ".empty"}, 64'(Empty),     64'(e.empty));
      checkValue({tag, ".ovf"},   64'(Overflow),  64'(e.ovf));
      checkValue({tag, ".unf"},   64'(Underflow), 64'(e.unf));
    end
  endtask

  task automatic step(input string tag, input logic [1:0] pu, input logic [1:0] po,
                      input logic [1:0] fl, input logic [15:0] d0, input logic [15:0] d1);
    @(negedge CLK);
    Push = pu;
    Pop = po;
    Flush = fl;
    PushData = {d1, d0};
    modelOp(0, pu[0], po[0], fl[0], d0);
    modelOp(1, pu[1], po[1], fl[1], d1);
    expQ.push_back(snap());
    @(posedge CLK);
    #1;
    compareNext(tag);
    Push = 2'b00;
    Pop = 2'b00;
    Flush = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    modelReset();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    expQ.push_back(snap());
    compareNext("reset");

    for (int k = 1; k <= D; k++) step($sformatf("fill%0d", k), 2'b01, 2'b00, 2'b00, 16'(k), 16'h0);
`ifdef STACK_BANK_GUARD_EN
    step("ovf_push", 2'b01, 2'b00, 2'b00, 16'd99, 16'h0);
`endif
    step("swap_full", 2'b01, 2'b01, 2'b00, 16'd77, 16'h0);
    for (int k = 1; k <= D; k++) step($sformatf("drain%0d", k), 2'b00, 2'b01, 2'b00, 16'h0, 16'h0);

    step("dn_pushA", 2'b10, 2'b00, 2'b00, 16'h0, 16'h000A);
    step("dn_pushB", 2'b10, 2'b00, 2'b00, 16'h0, 16'h000B);
    step("dn_pushC", 2'b10, 2'b00, 2'b00, 16'h0, 16'h000C);
    step("dn_swapD", 2'b10, 2'b10, 2'b00, 16'h0, 16'h000D);
    step("dn_pop",   2'b00, 2'b10, 2'b00, 16'h0, 16'h0);

    step("sim_flush1", 2'b00, 2'b00, 2'b10, 16'h0, 16'h0);
    step("sim_push7",  2'b10, 2'b00, 2'b00, 16'h0, 16'd7);
    step("sim_push9",  2'b10, 2'b00, 2'b00, 16'h0, 16'd9);
    step("sim_both",   2'b01, 2'b10, 2'b00, 16'd5, 16'h0);

    step("pop_last1", 2'b00, 2'b10, 2'b00, 16'h0, 16'h0);
`ifdef STACK_BANK_GUARD_EN
    step("unf_pop1", 2'b00, 2'b10, 2'b00, 16'h0, 16'h0);
    for (int k = 1; k < D; k++) step($sformatf("refill%0d", k), 2'b01, 2'b00, 2'b00, 16'(k + 100), 16'h0);
    step("ovf_again", 2'b01, 2'b00, 2'b00, 16'h0BAD, 16'h0);
`else
    for (int k = 1; k < D; k++) step($sformatf("refill%0d", k), 2'b01, 2'b00, 2'b00, 16'(k + 100), 16'h0);
    step("wrap_push", 2'b01, 2'b00, 2'b00, 16'h0BAD, 16'h0);
`endif
    step("flush_both", 2'b00, 2'b00, 2'b11, 16'h0, 16'h0);

    step("pre_all1", 2'b11, 2'b00, 2'b00, 16'h0011, 16'h0022);
    step("all_strobes", 2'b11, 2'b11, 2'b11, 16'h0033, 16'h0044);

    for (int k = 0; k < 3; k++) step($sformatf("burst%0d", k), 2'b11, 2'b00, 2'b00, 16'(k + 200), 16'(k + 300));
    @(negedge CLK);
    Push = 2'b11;
    PushData = {16'h0EEE, 16'h0DDD};
    #2;
    RST_N = 1'b0;
    #1;
    modelReset();
    expQ.push_back(snap());
    compareNext("arst_async");
    @(posedge CLK);
    #1;
    expQ.push_back(snap());
    compareNext("arst_held");
    @(negedge CLK);
    Push = 2'b00;
    RST_N = 1'b1;
    step("post_reset", 2'b01, 2'b00, 2'b00, 16'h1234, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/stack_bank.md
# stack_bank

Parametrised multi-channel hardware stack for the JALA-CPU datapath, generalising the single main-stack/return-stack pointer pair into NUM_STACKS independent LIFO channels. Each channel has its own on-chip storage, occupancy counter, stack-pointer address output and a registered top-of-stack value. Channels can grow up (main-stack style) or down (return-stack style). The block sits beside the register file and memory stage, and is driven by the control unit's push/pop/flush strobes.

## Interface
Parameters:
- WIDTH, 16, data and address width in bits
- DEPTH, 32, entries per stack; power of two, at least 2
- NUM_STACKS, 2, number of independent channels
- GROW_DOWN, 2'b10, bit i set means stack i's pointer decrements on push
- STACK_BASE, {16'hFFFF,16'h0000}, packed NUM_STACKS×WIDTH reset pointer values; stack 0 in the LSBs

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- Push  in  NUM_STACKS  per-channel push strobe
- Pop  in  NUM_STACKS  per-channel pop strobe
- Flush  in  NUM_STACKS  per-channel clear strobe
- PushData  in  NUM_STACKS×WIDTH  packed data to push
- TopOut  out  NUM_STACKS×WIDTH  registered top-of-stack; 0 when empty
- SPOut  out  NUM_STACKS×WIDTH  stack-pointer address
- Count  out  NUM_STACKS×($clog2(DEPTH)+1)  occupancy
- Full  out  NUM_STACKS  Count == DEPTH
- Empty  out  NUM_STACKS  Count == 0
- Overflow  out  NUM_STACKS  sticky: push was attempted while full
- Underflow  out  NUM_STACKS  sticky: pop was attempted while empty

## Operation
- Channels are fully independent. All strobes for all channels may be active in the same cycle.
- Per-channel priority: Flush > (Push & Pop) > Push > Pop > idle.
- **Flush:** Count←0, TopOut←0, Overflow and Underflow cleared. Storage contents are don't-care.
- **Push only:** element stored, Count+1, TopOut←PushData.
- **Pop only:** Count−1, TopOut←next element below the top, or 0 if the result is empty.
- **Push & Pop (exchange):**
  - Non-empty: Count unchanged, top entry replaced, TopOut←PushData.
  - Empty: treated as push only, and no underflow is raised.
- **SPOut:**
  - Grows up: STACK_BASE[i] + Count.
  - Grows down: STACK_BASE[i] − Count.
  - Arithmetic is modulo 2^WIDTH, so STACK_BASE 16'h0000 growing down gives FFFF, FFFE, …
- Full and Empty are combinational functions of Count.
- Reset values:
  - Count = 0, TopOut = 0, Full = 0, Empty = 1.
  - SPOut = STACK_BASE.
  - Overflow = 0, Underflow = 0.
  - Storage is not reset.

## Timing
- Single clock. All state updates occur on the rising edge of CLK.
- Strobes are sampled at the edge. TopOut, Count and SPOut reflect the operation immediately after that same edge (latency 1, no bubble).
- Back-to-back operations every cycle are allowed. A pop in cycle k+1 returns the value pushed in cycle k.
- Push while full (guard enabled): no state change, and Overflow sets on that edge.
- Pop while empty (guard enabled): no state change, and Underflow sets on that edge.
- Error flags stay set until Flush or reset.
- Exchange on a full stack is legal and does not raise Overflow.
- RST_N asserted mid-operation clears state asynchronously. The first operation accepted is the one at the first rising edge after deassertion.

## Configuration
- Macro: STACK_BANK_GUARD_EN.
- **Defined:**
  - Push on a full stack and pop on an empty stack are suppressed.
  - Overflow and Underflow are sticky as described above.
- **Undefined:**
  - No suppression. Count wraps modulo DEPTH+1 (a push at DEPTH goes to 0, a pop at 0 goes to DEPTH), and the oldest entry is overwritten.
  - Overflow and Underflow are tied to 0.
  - The SPOut formula is unchanged.

## Test plan
- **Reset:** RST_N low, then high → SPOut0 = 0000, SPOut1 = FFFF, Empty = 2'b11, TopOut = 0, Count = 0.
- **Fill and drain stack 0:** push 1..32 in consecutive cycles → Full0 = 1, SPOut0 = 0020, TopOut0 = 32. Then pop 32 times → TopOut0 steps 31..1, then 0; SPOut0 = 0000.
- **Grow-down stack 1:** push A, B, C → SPOut1 = FFFC, TopOut1 = C. Then exchange with D → Count1 = 3, TopOut1 = D. Then pop → TopOut1 = B.
- **Guard (STACK_BANK_GUARD_EN defined):** push onto full stack 0 → Count0 stays 32, Overflow0 = 1. Pop on empty stack 1 → Underflow1 = 1. Flush both → flags cleared, Count = 0.
- **Simultaneous channels:** push 5 on stack 0 and pop stack 1 (holding 7 over 9) in the same cycle → TopOut0 = 5, TopOut1 = 7, each count changes by one.
- **Asynchronous reset mid-burst:** assert RST_N low between edges during a push burst → outputs return to reset values before the next edge, with no partial update.
